rpm_telemetry_tx: RTL and testbench
===================================

# rpm_telemetry_tx

Transmit-side UART block: the counterpart of the existing UART receive path. It latches the latest RPM measurement from each encoder channel's RPM reader and serialises it onto `uart_tx` as fixed 5-byte frames, 8N1. This lets the host monitor motor speed while it sends set-points and parameters the other way. It sits in `top` beside `UART_controller` and is fed directly by the four RPM reader instances.

## Interface
- `CLK_FREQ_HZ`, 27_000_000, system clock frequency.
- `BAUD`, 115200, line rate; `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD` (integer truncation, 234 at defaults).
- `DATA_WIDTH`, 16, RPM word width; framing is defined for 16 only.
- `NUM_CHN`, 4, number of RPM channels, 1..8.
- `CHN_WIDTH`, 3 (localparam), channel index width.
- `clk`  in  1  system clock; single clock domain.
- `rstn`  in  1  reset, asynchronous, active-low.
- `rpm_valid_i`  in  NUM_CHN  per-channel one-cycle strobe: new RPM word available.
- `rpm_data_i`  in  NUM_CHN*DATA_WIDTH  packed RPM words; channel k occupies bits [k*16+15 : k*16].
- `uart_tx`  out  1  serial line, idle high.
- `busy_o`  out  1  high while a frame is being shifted.
- `frame_done_o`  out  1  one-cycle pulse at the end of the last stop bit of each frame.

## Operation
- **Holding stage.** Each channel has a 16-bit hold register and a `pending` flag.
  - `rpm_valid_i[k]` loads `hold[k]` with the channel-k word and sets `pending[k]`.
  - A newer word overwrites an unsent one. No queueing; last value wins.
- **Scheduler (round-robin).**
  - When the frame FSM is in IDLE and any `pending` bit is set, select the first set bit, searching from `last_chn+1` modulo NUM_CHN.
  - `last_chn` resets to NUM_CHN-1, so channel 0 has first priority out of reset.
- **Snapshot.** In LOAD, copy `hold[sel]` into the frame buffer, clear `pending[sel]` and set `last_chn = sel`.
  - If `rpm_valid_i[sel]` is high in that same cycle, the set wins: `pending[sel]` stays 1 and `hold` takes the new word. The frame in flight carries the old word.
- **Frame format**, byte order:
  - B0 = 0xA5
  - B1 = {5'b0, chn[2:0]}
  - B2 = data[15:8]
  - B3 = data[7:0]
  - B4 = (B0+B1+B2+B3) mod 256
- **Byte serialiser.** Start bit 0, eight data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- **FSM states.**
  - IDLE: leave when any `pending` is set.
  - LOAD: one cycle, then START.
  - START: after CLKS_PER_BIT cycles, go to DATA.
  - DATA: 8 bits, bit counter 0..7, then STOP.
  - STOP: at the end of the stop bit, if byte index < 4, increment it and go to START. If the index is 4, pulse `frame_done_o` and go to IDLE.
- **Back-to-back frames.** No inter-frame gap beyond the IDLE+LOAD cycles. A newly pending channel is served right after `frame_done_o`.
- **Counters.** Baud counter is 0..CLKS_PER_BIT-1 and wraps. Bit counter is 3 bits; byte index is 3 bits.

## Timing
- **Reset values.** `uart_tx`=1, `busy_o`=0, `frame_done_o`=0. All `pending`=0, hold registers=0, FSM=IDLE, `last_chn`=NUM_CHN-1.
- **Reset mid-frame.** `uart_tx` goes high asynchronously and the frame is discarded. After release, nothing is sent until a new `rpm_valid_i`.
- `uart_tx`, `busy_o` and `frame_done_o` are registered outputs; there are no combinational paths from inputs to outputs.
- **Latency.** `rpm_valid_i` sampled at edge N sets `pending` at N. The FSM enters LOAD at N+1 and START at N+2, so `uart_tx` falls after edge N+2.
- **Busy window.** `busy_o` rises with the START entry and falls with `frame_done_o`.
- **Frame duration.** 50*CLKS_PER_BIT cycles = 11700 at defaults.
- **Simultaneous strobes.** Any set of channels may strobe in the same cycle. All are captured, and they are sent in round-robin order.
- **Overrun.** If the channel update rate exceeds the frame rate, intermediate values are dropped silently. This is by design.

## Test plan
- **Single frame.** Channel 2 strobes 0x1234 -> bytes A5 02 12 34 ED on the line. `frame_done_o` pulses once, and `busy_o` is high for 11700 cycles.
- **Bit timing.** Idle, then one frame -> every bit interval measures exactly 234 cycles. Start bit is 0, stop bit is 1, and `uart_tx` falls 2 edges after the strobe edge.
- **Simultaneous strobes.** All four channels strobe 0x0010, 0x0020, 0x0030, 0x0040 in one cycle -> four contiguous frames for channels 0,1,2,3 with checksums B5, C6, D7, E8.
- **Overwrite while busy.** During a channel-0 frame, channel 1 strobes 0x0001 and then 0x00FF -> exactly one channel-1 frame follows, payload 00 FF, checksum A5.
- **Checksum wrap.** Channel 3 strobes 0xFFFF -> bytes A5 03 FF FF A6.
- **Reset mid-frame.** Deassert `rstn` during byte B2 -> `uart_tx` is 1 immediately and `busy_o`=0. No frame is sent after release until a new strobe; a new strobe on channel 0 with 0x0000 gives A5 00 00 00 A5.

Source files
------------

// File: rtl/rpm_telemetry_tx.sv
// -----------------------------------------------------------------------------
// rpm_telemetry_tx
//
// Transmit-side UART telemetry block. It keeps the most recent RPM word from
// each encoder channel, serves the channels in round-robin order, and sends
// each word as a fixed 5-byte 8N1 frame:
//   A5, {5'b0, chn}, data[15:8], data[7:0], checksum (sum of first four, mod 256)
//
// Ports
//   clk           system clock, single domain
//   rstn          asynchronous active-low reset
//   rpm_valid_i   per-channel one-cycle strobe: new RPM word available
//   rpm_data_i    packed RPM words, channel k at [k*16 +: 16]
//   uart_tx       serial line, idle high (registered)
//   busy_o        high while a frame is on the line (registered)
//   frame_done_o  one-cycle pulse at the end of each frame's last stop bit
// -----------------------------------------------------------------------------
module rpm_telemetry_tx #(
  parameter int CLK_FREQ_HZ = 27_000_000,
  parameter int BAUD        = 115_200,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CHN     = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_CHN-1:0]            rpm_valid_i,
  input  logic [NUM_CHN*DATA_WIDTH-1:0] rpm_data_i,
  output logic                          uart_tx,
  output logic                          busy_o,
  output logic                          frame_done_o
);

  localparam int CHN_WIDTH    = 3;
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]                           state_q, state_d;
  logic [NUM_CHN-1:0][DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [NUM_CHN-1:0]                   pending_q, pending_d;
  logic [CHN_WIDTH-1:0]                 last_chn_q, last_chn_d;
  logic [CHN_WIDTH-1:0]                 chn_q, chn_d;
  logic [DATA_WIDTH-1:0]                data_q, data_d;
  logic [BAUD_W-1:0]                    baud_q, baud_d;
  logic [2:0]                           bit_q, bit_d;
  logic [2:0]                           byte_q, byte_d;
  logic                                 tx_q, tx_d;
  logic                                 busy_q, busy_d;
  logic                                 done_q, done_d;

  logic                                 rr_found;
  logic [CHN_WIDTH-1:0]                 rr_sel;
  logic [7:0]                           cur_byte;
  logic [7:0]                           checksum;
  logic                                 bit_end;

  assign uart_tx      = tx_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign bit_end      = (baud_q == BAUD_LAST);

  // Round-robin pick: the first pending channel at distance 1..NUM_CHN from
  // the channel served last.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    for (int i = 1; i <= NUM_CHN; i++) begin
      for (int k = 0; k < NUM_CHN; k++) begin
        if (!rr_found && pending_q[k] && (k == (int'(last_chn_q) + i) % NUM_CHN)) begin
          rr_found = 1'b1;
          rr_sel   = CHN_WIDTH'(k);
        end
      end
    end
  end

  // The byte being shifted is selected from the frozen snapshot, so only the
  // 16-bit word and channel number need to be stored per frame.
  assign checksum = SYNC_BYTE + {5'b0, chn_q} + data_q[15:8] + data_q[7:0];

  always_comb begin
    case (byte_q)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = {5'b0, chn_q};
      3'd2:    cur_byte = data_q[15:8];
      3'd3:    cur_byte = data_q[7:0];
      default: cur_byte = checksum;
    endcase
  end

  always_comb begin
    // NOTE: every next-state variable takes its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    hold_d     = hold_q;
    pending_d  = pending_q;
    last_chn_d = last_chn_q;
    chn_d      = chn_q;
    data_d     = data_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          chn_d   = rr_sel;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        for (int k = 0; k < NUM_CHN; k++) begin
          if (chn_q == CHN_WIDTH'(k)) begin
            data_d       = hold_q[k];
            pending_d[k] = 1'b0;
          end
        end
        last_chn_d = chn_q;
        byte_d     = 3'd0;
        baud_d     = '0;
        tx_d       = 1'b0;
        busy_d     = 1'b1;
        state_d    = S_START;
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = cur_byte[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (byte_q == 3'd4) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            byte_d  = byte_q + 3'd1;
            tx_d    = 1'b0;
            state_d = S_START;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // A strobe is applied after the LOAD clear so that a word arriving in the
    // snapshot cycle stays pending; the frame in flight keeps the old word.
    for (int k = 0; k < NUM_CHN; k++) begin
      if (rpm_valid_i[k]) begin
        hold_d[k]    = rpm_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        pending_d[k] = 1'b1;
      end
    end
  end

  // NOTE: the hold registers are small and their zero value is visible
  // state, so they sit in the reset list like any other flop rather than
  // being treated as an unreset memory.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      pending_q  <= '0;
      last_chn_q <= CHN_WIDTH'(NUM_CHN - 1);
      chn_q      <= '0;
      data_q     <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here; every flop samples the _d values
      // computed from the previous state, independent of statement order.
      state_q    <= state_d;
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      last_chn_q <= last_chn_d;
      chn_q      <= chn_d;
      data_q     <= data_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_rpm_telemetry_tx.sv
// -----------------------------------------------------------------------------
// tb_rpm_telemetry_tx
//
// Self-checking bench for rpm_telemetry_tx. A shortened bit time (16 clocks)
// keeps the run compact; every line sample is compared against the ideal 8N1
// waveform of the expected frame, so bit length, bit order and framing are
// all checked cycle by cycle.
// -----------------------------------------------------------------------------
module tb_rpm_telemetry_tx;

  localparam int CLK_FREQ_HZ = 27_000_000;
  localparam int BAUD        = 1_687_500;
  localparam int CPB         = CLK_FREQ_HZ / BAUD;   // 16 clocks per bit
  localparam int NUM_CHN     = 4;
  localparam int DW          = 16;
  localparam int FRAME_CYC   = 50 * CPB;

  typedef logic [7:0] frame_t [5];

  typedef struct {
    int          chn;
    logic [15:0] data;
    frame_t      exp;
  } vec_t;

  logic                  clk;
  logic                  rstn;
  logic [NUM_CHN-1:0]    rpm_valid_i;
  logic [NUM_CHN*DW-1:0] rpm_data_i;
  logic                  uart_tx;
  logic                  busy_o;
  logic                  frame_done_o;

  int checks = 0;
  int errors = 0;

  rpm_telemetry_tx #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD),
    .DATA_WIDTH  (DW),
    .NUM_CHN     (NUM_CHN)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rpm_valid_i  (rpm_valid_i),
    .rpm_data_i   (rpm_data_i),
    .uart_tx      (uart_tx),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input int chn, input logic [15:0] data,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic [7:0] b4);
    vec_t v;
    v.chn    = chn;
    v.data   = data;
    v.exp[0] = b0;
    v.exp[1] = b1;
    v.exp[2] = b2;
    v.exp[3] = b3;
    v.exp[4] = b4;
    return v;
  endfunction

  // Drives a one-cycle strobe; returns at the negedge after the sampling edge.
  task automatic strobe(input logic [NUM_CHN-1:0] mask,
                        input logic [NUM_CHN*DW-1:0] data);
    @(negedge clk);
    rpm_valid_i = mask;
    rpm_data_i  = data;
    @(negedge clk);
    rpm_valid_i = '0;
  endtask

  // Counts negedges until the line goes low, bounded.
  task automatic wait_start(output int lat);
    lat = 0;
    while (uart_tx !== 1'b0 && lat < 4 * CPB) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Entered on the first low sample; returns on the sample after the frame.
  task automatic check_frame(input string name, input frame_t exp);
    logic [7:0] got [5];
    int bad_wave, bad_busy, bad_done, bit_idx, bi, pos;
    logic e;
    bad_wave = 0;
    bad_busy = 0;
    bad_done = 0;
    for (int b = 0; b < 5; b++) got[b] = 8'h00;
    for (int i = 0; i < FRAME_CYC; i++) begin
      bit_idx = i / CPB;
      bi      = bit_idx / 10;
      pos     = bit_idx % 10;
      if (pos == 0)      e = 1'b0;
      else if (pos == 9) e = 1'b1;
      else               e = exp[bi][pos-1];
      if (uart_tx !== e) bad_wave++;
      if (pos >= 1 && pos <= 8 && (i % CPB) == CPB / 2) got[bi][pos-1] = uart_tx;
      if (busy_o !== 1'b1) bad_busy++;
      if (frame_done_o !== 1'b0) bad_done++;
      @(negedge clk);
    end
    for (int b = 0; b < 5; b++) check($sformatf("%s byte%0d", name, b), got[b], exp[b]);
    check({name, " waveform_errs"}, bad_wave, 0);
    check({name, " busy_low_in_frame"}, bad_busy, 0);
    check({name, " done_early"}, bad_done, 0);
    check({name, " done_pulse"}, frame_done_o, 1'b1);
    check({name, " busy_after"}, busy_o, 1'b0);
  endtask

  task automatic expect_quiet(input string name, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy_o !== 1'b0 || frame_done_o !== 1'b0) bad++;
    end
    check(name, bad, 0);
  endtask

  vec_t vecs[4];
  vec_t sim[4];

  initial begin
    int lat;
    logic [NUM_CHN*DW-1:0] d;
    frame_t f;

    // Last single vector is channel 3, so the simultaneous test starts its
    // round-robin search at channel 0.
    vecs[0] = mk(2, 16'h1234, 8'hA5, 8'h02, 8'h12, 8'h34, 8'hED);
    vecs[1] = mk(1, 16'h5A3C, 8'hA5, 8'h01, 8'h5A, 8'h3C, 8'h3C);
    vecs[2] = mk(0, 16'h8001, 8'hA5, 8'h00, 8'h80, 8'h01, 8'h26);
    vecs[3] = mk(3, 16'hFFFF, 8'hA5, 8'h03, 8'hFF, 8'hFF, 8'hA6);

    sim[0] = mk(0, 16'h0010, 8'hA5, 8'h00, 8'h00, 8'h10, 8'hB5);
    sim[1] = mk(1, 16'h0020, 8'hA5, 8'h01, 8'h00, 8'h20, 8'hC6);
    sim[2] = mk(2, 16'h0030, 8'hA5, 8'h02, 8'h00, 8'h30, 8'hD7);
    sim[3] = mk(3, 16'h0040, 8'hA5, 8'h03, 8'h00, 8'h40, 8'hE8);

    rstn        = 1'b0;
    rpm_valid_i = '0;
    rpm_data_i  = '0;
    repeat (3) @(negedge clk);
    check("reset uart_tx", uart_tx, 1'b1);
    check("reset busy", busy_o, 1'b0);
    check("reset done", frame_done_o, 1'b0);
    rstn = 1'b1;
    expect_quiet("idle after reset", 4 * CPB);

    // Single-channel frames from the table.
    foreach (vecs[v]) begin
      d = '0;
      d[vecs[v].chn*DW +: DW] = vecs[v].data;
      strobe(NUM_CHN'(1) << vecs[v].chn, d);
      wait_start(lat);
      check($sformatf("vec%0d latency", v), lat, 2);
      check_frame($sformatf("vec%0d", v), vecs[v].exp);
    end
    expect_quiet("idle after vectors", 4 * CPB);

    // All four channels at once: contiguous frames in order 0..3.
    strobe(4'hF, {16'h0040, 16'h0030, 16'h0020, 16'h0010});
    foreach (sim[k]) begin
      wait_start(lat);
      check($sformatf("sim%0d gap", k), lat, 2);
      check_frame($sformatf("sim%0d", k), sim[k].exp);
    end
    expect_quiet("idle after simultaneous", 4 * CPB);

    // Channel 1 updated twice during a channel-0 frame: only the last word goes.
    strobe(4'b0001, 64'h0102);
    wait_start(lat);
    check("ow ch0 latency", lat, 2);
    f = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'hA8};
    fork
      check_frame("ow ch0", f);
      begin
        repeat (5 * CPB) @(negedge clk);
        strobe(4'b0010, 64'h0001 << 16);
        repeat (3 * CPB) @(negedge clk);
        strobe(4'b0010, 64'h00FF << 16);
      end
    join
    wait_start(lat);
    check("ow ch1 gap", lat, 2);
    f = '{8'hA5, 8'h01, 8'h00, 8'hFF, 8'hA5};
    check_frame("ow ch1", f);
    expect_quiet("ow single ch1 frame", 4 * CPB);

    // Reset during B2's start bit: line must return high at once.
    strobe(4'b0100, 64'hABCD << 32);
    wait_start(lat);
    check("rst latency", lat, 2);
    repeat (20 * CPB) @(negedge clk);
    check("rst pre tx low", uart_tx, 1'b0);
    #3 rstn = 1'b0;
    #1;
    check("rst async tx", uart_tx, 1'b1);
    check("rst async busy", busy_o, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    expect_quiet("rst no resend", 60 * CPB);
    strobe(4'b0001, 64'h0000);
    wait_start(lat);
    check("post rst latency", lat, 2);
    f = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5};
    check_frame("post rst", f);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
